// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: panel controller for a two-digit hex up/down counter.
// Raw keys are synchronised and debounced into one-cycle press pulses.
// An IDLE/RUN/PAUSE state machine turns those pulses into automatic or
// manual step events. The block owns the 8-bit count and time-shares a
// six-digit scan port across count-low, count-high and the state code.
//
// Strobe semantics: step_pulse and carry are single-cycle, registered
// strobes that are high in exactly the cycle cnt_val shows the new value.
// They need no acknowledge.

module cnt_seq_ctrl #(
  parameter int DEB_CYCLES = 1000,
  parameter int DIV_STEP   = 100000,
  parameter int SCAN_DIV   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_clr_n,
  input  logic       key_start_n,
  input  logic       key_step_n,
  input  logic       minus,
  output logic [7:0] cnt_val,
  output logic [1:0] state,
  output logic       step_pulse,
  output logic       carry,
  output logic       sat,
  output logic [5:0] scan,
  output logic [3:0] dig
);

  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PRE_W  = (DIV_STEP   > 1) ? $clog2(DIV_STEP)   : 1;
  localparam int SCAN_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV_STEP - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  // Key index: 0 = clear, 1 = start/pause, 2 = manual step
  logic [2:0] key_raw;
  assign key_raw = {key_step_n, key_start_n, key_clr_n};

  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       deb_lvl_q, deb_lvl_d;
  logic [DEB_W-1:0] deb_cnt_q [3];
  logic [DEB_W-1:0] deb_cnt_d [3];
  logic [2:0]       press_q, press_d;

  logic clr_p, start_p, step_p;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             step_ev;

  logic [7:0] cnt_q, cnt_d;
  logic       step_pulse_q, step_pulse_d;
  logic       carry_q, carry_d;

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        slot_q, slot_d;
  logic [5:0]        scan_q, scan_d;
  logic [3:0]        dig_q, dig_d;

  // Two-flop synchroniser per raw key; idle level is released (high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after DEB_CYCLES consecutive differing samples
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_lvl_d[i] = deb_lvl_q[i];
      deb_cnt_d[i] = deb_cnt_q[i];
      press_d[i]   = 1'b0;
      if (sync2_q[i] == deb_lvl_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_lvl_d[i] = sync2_q[i];
        deb_cnt_d[i] = '0;
        press_d[i]   = ~sync2_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      end
    end
  end

  // Debounce registers and registered press pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_lvl_q <= 3'b111;
      press_q   <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
    end else begin
      deb_lvl_q <= deb_lvl_d;
      press_q   <= press_d;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  // Coincident presses: clear beats start beats step; losers are dropped
  assign clr_p   = press_q[0];
  assign start_p = press_q[1] & ~press_q[0];
  assign step_p  = press_q[2] & ~press_q[1] & ~press_q[0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: clear from anywhere, start toggles RUN/PAUSE
  always_comb begin
    state_d = state_q;
    if (clr_p) begin
      state_d = S_IDLE;
    end else if (start_p) begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: prescaler control and the step event (auto in RUN, manual in PAUSE)
  always_comb begin
    pre_d   = pre_q;
    step_ev = 1'b0;
    if (clr_p) begin
      pre_d = '0;
    end else if (start_p) begin
      // Entering RUN restarts the prescaler; RUN->PAUSE freezes it
      if (state_q != S_RUN) pre_d = '0;
    end else if (state_q == S_RUN) begin
      if (pre_q == PRE_LAST) begin
        step_ev = 1'b1;
        pre_d   = '0;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end else if (state_q == S_PAUSE && step_p) begin
      step_ev = 1'b1;
    end
  end

  // Prescaler register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  // Count datapath: wrap on up, saturate at 00 on down
  always_comb begin
    cnt_d        = cnt_q;
    step_pulse_d = 1'b0;
    carry_d      = 1'b0;
    if (clr_p) begin
      cnt_d = 8'h00;
    end else if (step_ev) begin
      step_pulse_d = 1'b1;
      if (!minus) begin
        cnt_d   = cnt_q + 8'h01;
        carry_d = (cnt_q == 8'hFF);
      end else if (cnt_q != 8'h00) begin
        cnt_d = cnt_q - 8'h01;
      end
    end
  end

  // Count and strobe registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= 8'h00;
      step_pulse_q <= 1'b0;
      carry_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      step_pulse_q <= step_pulse_d;
      carry_q      <= carry_d;
    end
  end

  // Scan scheduler: hold each slot SCAN_DIV cycles, cycle 0 -> 1 -> 2 -> 0
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    slot_d     = slot_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      slot_d     = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
    end
    case (slot_q)
      2'd0: begin
        scan_d = 6'b001000;
        dig_d  = cnt_q[3:0];
      end
      2'd1: begin
        scan_d = 6'b010000;
        dig_d  = cnt_q[7:4];
      end
      default: begin
        scan_d = 6'b100000;
        dig_d  = {2'b00, state_q};
      end
    endcase
  end

  // Scan registers: scan and dig always update together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      slot_q     <= 2'd0;
      scan_q     <= 6'b001000;
      dig_q      <= 4'h0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      slot_q     <= slot_d;
      scan_q     <= scan_d;
      dig_q      <= dig_d;
    end
  end

  assign cnt_val    = cnt_q;
  assign state      = state_q;
  assign step_pulse = step_pulse_q;
  assign carry      = carry_q;
  assign sat        = minus & (cnt_q == 8'h00);
  assign scan       = scan_q;
  assign dig        = dig_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl with small parameters
// (DEB_CYCLES=4, DIV_STEP=10, SCAN_DIV=3). Expected values are hand-derived.

module tb_cnt_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_clr_n, key_start_n, key_step_n, minus;
  logic [7:0] cnt_val;
  logic [1:0] state;
  logic       step_pulse, carry, sat;
  logic [5:0] scan;
  logic [3:0] dig;

  int n_pass  = 0;
  int n_total = 0;
  int step_cnt  = 0;
  int carry_cnt = 0;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  cnt_seq_ctrl #(.DEB_CYCLES(4), .DIV_STEP(10), .SCAN_DIV(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_clr_n   (key_clr_n),
    .key_start_n (key_start_n),
    .key_step_n  (key_step_n),
    .minus       (minus),
    .cnt_val     (cnt_val),
    .state       (state),
    .step_pulse  (step_pulse),
    .carry       (carry),
    .sat         (sat),
    .scan        (scan),
    .dig         (dig)
  );

  // Clock
  always #5 clk = ~clk;

  // Strobe monitors sampled on the inactive edge
  always @(negedge clk) begin
    if (step_pulse === 1'b1) step_cnt  <= step_cnt + 1;
    if (carry === 1'b1)      carry_cnt <= carry_cnt + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Wait (bounded) for the next negedge at which step_pulse is high
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (step_pulse !== 1'b1 && n < 40);
  endtask

  // Step along until cnt_val reaches target; returns on that step's negedge
  task automatic wait_val(input logic [7:0] target, input string tag);
    int n;
    int k;
    k = 0;
    while (cnt_val !== target && k < 300) begin
      wait_step(n);
      k++;
    end
    chk(tag, cnt_val, target);
  endtask

  // Press the selected keys now, hold, release and let release settle
  task automatic press(input logic c, input logic s, input logic p);
    if (c) key_clr_n   = 1'b0;
    if (s) key_start_n = 1'b0;
    if (p) key_step_n  = 1'b0;
    repeat (10) @(negedge clk);
    key_clr_n   = 1'b1;
    key_start_n = 1'b1;
    key_step_n  = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int n;
    int sc;
    int cc;
    logic [5:0] prev_scan;
    logic [5:0] exp_scan;
    logic [3:0] exp_dig;

    // Reset
    rst = 1'b1;
    key_clr_n = 1'b1; key_start_n = 1'b1; key_step_n = 1'b1; minus = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cnt",   cnt_val, 8'h00);
    chk("rst_state", {6'd0, state}, {6'd0, ST_IDLE});
    chk("rst_step",  {7'd0, step_pulse}, 8'h00);
    chk("rst_carry", {7'd0, carry}, 8'h00);
    chk("rst_scan",  {2'd0, scan}, 8'h08);
    chk("rst_dig",   {4'd0, dig}, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Bounce on start: 2-cycle phases never reach 4 stable samples
    for (int i = 0; i < 10; i++) begin
      key_start_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    chk("bounce_idle", {6'd0, state}, {6'd0, ST_IDLE});
    key_start_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_run", {6'd0, state}, {6'd0, ST_RUN});
    key_start_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("release_no_pulse", {6'd0, state}, {6'd0, ST_RUN});

    // Auto up count to FE, then FF, then wrap to 00 with carry
    wait_val(8'hFE, "reach_fe");
    wait_step(n);
    chk("period_ff", 8'(n), 8'd10);
    chk("cnt_ff", cnt_val, 8'hFF);
    chk("carry_ff", {7'd0, carry}, 8'h00);
    wait_step(n);
    chk("period_wrap", 8'(n), 8'd10);
    chk("cnt_wrap", cnt_val, 8'h00);
    chk("carry_wrap", {7'd0, carry}, 8'h01);
    @(negedge clk);
    chk("carry_one_cycle", {7'd0, carry}, 8'h00);
    chk("step_one_cycle", {7'd0, step_pulse}, 8'h00);

    // Pause right after the step to 01
    wait_step(n);
    chk("cnt_01", cnt_val, 8'h01);
    press(1'b0, 1'b1, 1'b0);
    chk("pause_state", {6'd0, state}, {6'd0, ST_PAUSE});
    chk("pause_cnt", cnt_val, 8'h01);

    // Manual down steps with saturation at 00
    minus = 1'b1;
    sc = step_cnt;
    cc = carry_cnt;
    press(1'b0, 1'b0, 1'b1);
    chk("down_00", cnt_val, 8'h00);
    chk("down_pulse1", 8'(step_cnt - sc), 8'd1);
    chk("sat_high", {7'd0, sat}, 8'h01);
    press(1'b0, 1'b0, 1'b1);
    chk("sat_hold", cnt_val, 8'h00);
    chk("sat_pulse2", 8'(step_cnt - sc), 8'd2);
    chk("sat_no_carry", 8'(carry_cnt - cc), 8'd0);

    // Step press while in RUN is ignored (checked before the first auto step)
    minus = 1'b0;
    sc = step_cnt;
    key_start_n = 1'b0;
    repeat (2) @(negedge clk);
    key_step_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("run_ign_state", {6'd0, state}, {6'd0, ST_RUN});
    chk("run_ign_cnt", cnt_val, 8'h00);
    chk("run_ign_pulse", 8'(step_cnt - sc), 8'd0);
    key_start_n = 1'b1;
    key_step_n  = 1'b1;
    repeat (8) @(negedge clk);

    // Borrow across nibbles: 10 -> 0F
    wait_val(8'h10, "reach_10");
    press(1'b0, 1'b1, 1'b0);
    chk("pause10_state", {6'd0, state}, {6'd0, ST_PAUSE});
    minus = 1'b1;
    press(1'b0, 1'b0, 1'b1);
    chk("borrow_0f", cnt_val, 8'h0F);
    chk("borrow_no_sat", {7'd0, sat}, 8'h00);

    // Clear and start together in RUN at 5A: clear wins
    minus = 1'b0;
    press(1'b0, 1'b1, 1'b0);
    chk("resume_run", {6'd0, state}, {6'd0, ST_RUN});
    wait_val(8'h5A, "reach_5a");
    press(1'b1, 1'b1, 1'b0);
    chk("clr_state", {6'd0, state}, {6'd0, ST_IDLE});
    chk("clr_cnt", cnt_val, 8'h00);
    repeat (20) @(negedge clk);
    chk("clr_stays_idle", {6'd0, state}, {6'd0, ST_IDLE});
    chk("clr_stays_00", cnt_val, 8'h00);

    // Scan sequence with 3C in PAUSE
    press(1'b0, 1'b1, 1'b0);
    wait_val(8'h3C, "reach_3c");
    press(1'b0, 1'b1, 1'b0);
    chk("pause3c_state", {6'd0, state}, {6'd0, ST_PAUSE});
    prev_scan = scan;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (prev_scan == 6'b100000 && scan == 6'b001000) break;
      prev_scan = scan;
    end
    for (int p = 0; p < 3; p++) begin
      case (p)
        0: begin exp_scan = 6'b001000; exp_dig = 4'hC; end
        1: begin exp_scan = 6'b010000; exp_dig = 4'h3; end
        default: begin exp_scan = 6'b100000; exp_dig = 4'h2; end
      endcase
      for (int k = 0; k < 3; k++) begin
        if (p != 0 || k != 0) @(negedge clk);
        chk($sformatf("scan_p%0d_c%0d", p, k), {2'd0, scan}, {2'd0, exp_scan});
        chk($sformatf("dig_p%0d_c%0d", p, k), {4'd0, dig}, {4'd0, exp_dig});
      end
    end
    @(negedge clk);
    chk("scan_wrap", {2'd0, scan}, 8'h08);
    chk("dig_wrap", {4'd0, dig}, 8'h0C);

    // Asynchronous reset mid-slot
    #2 rst = 1'b1;
    #1;
    chk("arst_scan",  {2'd0, scan}, 8'h08);
    chk("arst_dig",   {4'd0, dig}, 8'h00);
    chk("arst_cnt",   cnt_val, 8'h00);
    chk("arst_state", {6'd0, state}, {6'd0, ST_IDLE});
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
